// File: rtl/addsub_accumulator.sv
// Command-driven N-bit add/subtract/load/clear accumulator with a three-state
// IDLE -> EXEC -> HOLD handshake, signed-overflow flags and a saturating command counter.
module addsub_accumulator #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] operand,
  input  logic         clr_sticky,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] acc,
  output logic         c_out,
  output logic         overflow,
  output logic         ovf_sticky,
  output logic [7:0]   op_count,
  output logic [1:0]   state_dbg
);

  // Handshake: a command transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Each side
  // holds its payload stable until the transfer edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t       state, state_next;
  logic [1:0]   op_q;
  logic [N-1:0] operand_q;
  logic         accept;
  logic         is_sub;
  logic [N-1:0] op_b;
  logic [N:0]   sum;
  logic         arith_ovf;
  logic [N-1:0] acc_next;
  logic         c_next;
  logic         ovf_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = EXEC;
      EXEC:    state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    state_dbg = state;
    case (state)
      IDLE:    in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = in_valid && (state == IDLE);

  // SUB is acc + ~operand + 1, so c_out reads as "no borrow".
  assign is_sub    = (op_q == OP_SUB);
  assign op_b      = operand_q ^ {N{is_sub}};
  assign sum       = {1'b0, acc} + {1'b0, op_b} + {{N{1'b0}}, is_sub};
  assign arith_ovf = (acc[N-1] == op_b[N-1]) && (sum[N-1] != acc[N-1]);

  always_comb begin
    acc_next = '0;
    c_next   = 1'b0;
    ovf_next = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        acc_next = sum[N-1:0];
        c_next   = sum[N];
        ovf_next = arith_ovf;
      end
      OP_LOAD:  acc_next = operand_q;
      OP_CLEAR: acc_next = '0;
      default:  acc_next = '0;
    endcase
  end

  // Command capture isolates the in-flight result from later input changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_ADD;
      operand_q <= '0;
    end else if (accept) begin
      op_q      <= op;
      operand_q <= operand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (state == EXEC) begin
      acc      <= acc_next;
      c_out    <= c_next;
      overflow <= ovf_next;
    end
  end

  // A set at the EXEC closing edge takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ovf_sticky <= 1'b0;
    else if (state == EXEC && ovf_next) ovf_sticky <= 1'b1;
    else if (clr_sticky)              ovf_sticky <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             op_count <= 8'd0;
    else if (accept && op_count != 8'hFF) op_count <= op_count + 8'd1;
  end

endmodule
